// File: rtl/router_out_scheduler_pkg.sv
// Shared types and constants for the 1x3 router output scheduler.
package router_out_scheduler_pkg;

  localparam int         NPORTS    = 3;
  localparam logic [1:0] PORT_NONE = 2'd3;
  localparam int         LEN_MSB   = 7;
  localparam int         LEN_LSB   = 2;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_XFER_HDR    = 2'd1,
    S_XFER_BODY   = 2'd2,
    S_TIMEOUT_RST = 2'd3
  } sched_state_e;

  // Successor port modulo NPORTS; anything out of range folds back to 0.
  function automatic logic [1:0] port_next(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [NPORTS-1:0] port_onehot(input logic [1:0] p);
    logic [NPORTS-1:0] oh;
    case (p)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_out_scheduler_if.sv
// FIFO-side and downstream-side signals of the router output scheduler.
interface router_out_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              empty_0, empty_1, empty_2;
  logic [DATA_W-1:0] fifo_data_0, fifo_data_1, fifo_data_2;
  logic              data_ready;
  logic              read_enb_0, read_enb_1, read_enb_2;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [1:0]        grant_port;
  logic              soft_reset_0, soft_reset_1, soft_reset_2;
  logic              busy;

  modport master (
    input  empty_0, empty_1, empty_2,
    input  fifo_data_0, fifo_data_1, fifo_data_2,
    input  data_ready,
    output read_enb_0, read_enb_1, read_enb_2,
    output data_out, data_valid, grant_port,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output busy
  );

  modport slave (
    output empty_0, empty_1, empty_2,
    output fifo_data_0, fifo_data_1, fifo_data_2,
    output data_ready,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  data_out, data_valid, grant_port,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  busy
  );
endinterface

// File: rtl/router_out_scheduler_arbiter.sv
// Combinational 3-way round-robin pick: first requesting port at or after ptr.
module router_rr_arbiter
  import router_out_scheduler_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [1:0]        ptr,
  output logic              gnt_valid,
  output logic [1:0]        gnt_idx
);

  logic [1:0]        start;
  logic [1:0]        start_p1;
  logic [1:0]        start_p2;
  logic [NPORTS-1:0] rot;

  assign start    = (ptr > 2'd2) ? 2'd0 : ptr;
  assign start_p1 = port_next(start);
  assign start_p2 = port_next(start_p1);

  // rot[k] is the request of port (start + k) mod 3
  always_comb begin
    case (start)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
  end

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT_NONE;
    if (rot[0])      gnt_idx = start;
    else if (rot[1]) gnt_idx = start_p1;
    else if (rot[2]) gnt_idx = start_p2;
  end

endmodule

// File: rtl/router_out_scheduler.sv
// Output scheduler: round-robin packet grant over three FIFOs onto one
// valid/ready channel, with stall timeout that soft-resets the granted port.
module router_out_scheduler
  import router_out_scheduler_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input  logic                  clock,
  input  logic                  resetn,
  router_out_scheduler_if.master bus
);

  localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_e      state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [6:0]        bytes_left_q, bytes_left_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [NPORTS-1:0] srst_q, srst_d;

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] gnt_onehot;
  logic              arb_valid;
  logic [1:0]        arb_idx;
  logic              empty_g;
  logic [DATA_W-1:0] head_g;
  logic              in_xfer;
  logic              dvalid;
  logic              hs;

  assign req = ~{bus.empty_2, bus.empty_1, bus.empty_0};

  router_rr_arbiter u_arb (
    .req      (req),
    .ptr      (rr_ptr_q),
    .gnt_valid(arb_valid),
    .gnt_idx  (arb_idx)
  );

  // No grant reads as an empty FIFO with a zero head byte.
  always_comb begin
    empty_g = 1'b1;
    head_g  = '0;
    case (grant_q)
      2'd0: begin empty_g = bus.empty_0; head_g = bus.fifo_data_0; end
      2'd1: begin empty_g = bus.empty_1; head_g = bus.fifo_data_1; end
      2'd2: begin empty_g = bus.empty_2; head_g = bus.fifo_data_2; end
      default: ;
    endcase
  end

  assign gnt_onehot = port_onehot(grant_q);
  assign in_xfer    = (state_q == S_XFER_HDR) || (state_q == S_XFER_BODY);
  assign dvalid     = in_xfer && !empty_g;
  assign hs         = dvalid && bus.data_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    bytes_left_d = bytes_left_q;
    stall_d      = '0;
    srst_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          state_d = S_XFER_HDR;
        end
      end
      S_XFER_HDR: begin
        // Payload length plus the trailing parity byte.
        if (hs) begin
          bytes_left_d = 7'(head_g[LEN_MSB:LEN_LSB]) + 7'd1;
          state_d      = S_XFER_BODY;
        end
      end
      S_XFER_BODY: begin
        if (hs) begin
          if (bytes_left_q == 7'd1) begin
            state_d  = S_IDLE;
            rr_ptr_d = port_next(grant_q);
            grant_d  = PORT_NONE;
          end else begin
            bytes_left_d = bytes_left_q - 7'd1;
          end
        end
      end
      S_TIMEOUT_RST: begin
        state_d  = S_IDLE;
        rr_ptr_d = port_next(grant_q);
        grant_d  = PORT_NONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Only a present byte refused by downstream counts as a stall.
    if (dvalid && !bus.data_ready) begin
      stall_d = (&stall_q) ? stall_q : stall_q + CNT_W'(1);
      if (stall_q >= STALL_LAST) begin
        state_d = S_TIMEOUT_RST;
        srst_d  = gnt_onehot;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= PORT_NONE;
      rr_ptr_q     <= 2'd0;
      bytes_left_q <= '0;
      stall_q      <= '0;
      srst_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      bytes_left_q <= bytes_left_d;
      stall_q      <= stall_d;
      srst_q       <= srst_d;
    end
  end

  assign bus.data_valid   = dvalid;
  assign bus.data_out     = head_g;
  assign bus.grant_port   = grant_q;
  assign bus.read_enb_0   = hs && gnt_onehot[0];
  assign bus.read_enb_1   = hs && gnt_onehot[1];
  assign bus.read_enb_2   = hs && gnt_onehot[2];
  assign bus.soft_reset_0 = srst_q[0];
  assign bus.soft_reset_1 = srst_q[1];
  assign bus.soft_reset_2 = srst_q[2];
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_router_out_scheduler.sv
// Scoreboard bench for router_out_scheduler: FIFO models feed the DUT, a
// monitor checks every handshake and soft reset against an expected queue.
module tb_router_out_scheduler;
  import router_out_scheduler_pkg::*;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 30;

  typedef struct packed {
    logic       srst;
    logic [1:0] port;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_out_scheduler_if #(.DATA_W(DATA_W)) bus ();

  router_out_scheduler #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.master)
  );

  logic [7:0] fq [3][$];
  exp_t       exp_q [$];
  logic [2:0] pop_pend    = '0;
  logic [2:0] flush_pend  = '0;
  logic [2:0] force_empty = '0;
  int n_tests    = 0;
  int n_fail     = 0;
  int hs_total   = 0;
  int srst_total = 0;
  int cyc        = 0;

  function automatic logic [2:0] onehot3(input logic [1:0] p);
    return (p == 2'd3) ? 3'b000 : 3'(1 << p);
  endfunction

  // Packet image: header, len payload bytes counting up from base, parity.
  function automatic logic [7:0] pkt_byte(input logic [7:0] hdr, input logic [7:0] base, input int i);
    int len;
    logic [7:0] par;
    len = int'(hdr[7:2]);
    par = hdr;
    for (int j = 0; j < len; j++) par = par ^ (base + 8'(j));
    if (i == 0) return hdr;
    else if (i <= len) return base + 8'(i - 1);
    return par;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic load_pkt(input int p, input logic [7:0] hdr, input logic [7:0] base);
    for (int i = 0; i < int'(hdr[7:2]) + 2; i++) fq[p].push_back(pkt_byte(hdr, base, i));
  endtask

  task automatic expect_pkt(input int p, input logic [7:0] hdr, input logic [7:0] base);
    for (int i = 0; i < int'(hdr[7:2]) + 2; i++) exp_q.push_back({1'b0, 2'(p), pkt_byte(hdr, base, i)});
  endtask

  task automatic refresh_fifos();
    bus.empty_0     = (fq[0].size() == 0) || force_empty[0];
    bus.empty_1     = (fq[1].size() == 0) || force_empty[1];
    bus.empty_2     = (fq[2].size() == 0) || force_empty[2];
    bus.fifo_data_0 = bus.empty_0 ? 8'h00 : fq[0][0];
    bus.fifo_data_1 = bus.empty_1 ? 8'h00 : fq[1][0];
    bus.fifo_data_2 = bus.empty_2 ? 8'h00 : fq[2][0];
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < max_cyc) begin
      @(negedge clock); #1;
      k++;
    end
    check({name, " drained"}, 32'(exp_q.size()), 32'd0);
    check({name, " idle"}, 32'({bus.busy, bus.grant_port}), 32'({1'b0, PORT_NONE}));
  endtask

  // FIFO models: apply pops/flushes decided in the previous cycle after the edge.
  initial begin
    refresh_fifos();
    forever begin
      @(posedge clock); #2;
      for (int n = 0; n < 3; n++) begin
        if (!resetn || flush_pend[n]) fq[n].delete();
        else if (pop_pend[n] && fq[n].size() != 0) void'(fq[n].pop_front());
      end
      refresh_fifos();
    end
  end

  // Monitor: mid-cycle sampling of handshakes and soft resets.
  initial begin
    exp_t e;
    logic [2:0] rd, sr;
    forever begin
      @(negedge clock);
      cyc++;
      rd = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
      sr = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      pop_pend   = resetn ? rd : 3'b000;
      flush_pend = resetn ? sr : 3'b000;
      if (resetn && bus.data_valid && bus.data_ready) begin
        hs_total++;
        check("handshake pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("handshake", 32'({1'b0, bus.grant_port, rd, bus.data_out}),
                32'({e.srst, e.port, onehot3(e.port), e.data}));
        end
      end
      if (resetn && (|sr)) begin
        srst_total++;
        check("soft reset pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("soft reset", 32'({1'b1, bus.grant_port, sr}), 32'({e.srst, e.port, onehot3(e.port)}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1_bytes [5];
    int k, c0, h0, s0, dv_hits;

    resetn         = 1'b0;
    bus.data_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("reset data_valid", 32'(bus.data_valid), 32'd0);
    check("reset grant_port", 32'(bus.grant_port), 32'd3);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset read_enb", 32'({bus.read_enb_2, bus.read_enb_1, bus.read_enb_0}), 32'd0);
    check("reset soft_reset", 32'({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}), 32'd0);
    check("reset data_out", 32'(bus.data_out), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Two len-1 packets per port, all loaded together: 0,1,2,0,1,2.
    @(posedge clock); #1;
    for (int pk = 0; pk < 2; pk++)
      for (int n = 0; n < 3; n++) load_pkt(n, 8'h04, 8'(8'h40 + 16 * n + 2 * pk));
    for (int pk = 0; pk < 2; pk++)
      for (int n = 0; n < 3; n++) expect_pkt(n, 8'h04, 8'(8'h40 + 16 * n + 2 * pk));
    wait_drain("rr order", 200);

    // Port 1 only, header 0D: five bytes back to back.
    @(posedge clock); #1;
    t1_bytes = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h5A};
    h0 = hs_total;
    for (int i = 0; i < 5; i++) begin
      fq[1].push_back(t1_bytes[i]);
      exp_q.push_back({1'b0, 2'd1, t1_bytes[i]});
    end
    wait_drain("port1 packet", 50);
    check("port1 byte count", 32'(hs_total - h0), 32'd5);

    // Port 2 stalled by downstream: soft reset 30 cycles after valid rises.
    @(posedge clock); #1;
    bus.data_ready = 1'b0;
    s0 = srst_total;
    load_pkt(2, 8'h08, 8'h60);
    exp_q.push_back({1'b1, 2'd2, 8'h00});
    k = 0;
    while (!bus.data_valid && k < 20) begin @(negedge clock); #1; k++; end
    check("stall valid rose", 32'(bus.data_valid), 32'd1);
    c0 = cyc;
    k = 0;
    while (!bus.soft_reset_2 && k < 60) begin @(negedge clock); #1; k++; end
    check("stall timeout latency", 32'(cyc - c0), 32'(TIMEOUT));
    @(negedge clock); #1;
    check("after timeout", 32'({bus.grant_port, bus.soft_reset_2, bus.data_valid}), 32'({PORT_NONE, 2'b00}));
    check("timeout pulse count", 32'(srst_total - s0), 32'd1);
    @(posedge clock); #1;
    bus.data_ready = 1'b1;
    wait_drain("timeout", 20);

    // Ready returns on the last stalled cycle: handshake beats the timeout.
    @(posedge clock); #1;
    bus.data_ready = 1'b0;
    s0 = srst_total;
    load_pkt(0, 8'h04, 8'h77);
    expect_pkt(0, 8'h04, 8'h77);
    k = 0;
    while (!bus.data_valid && k < 20) begin @(negedge clock); #1; k++; end
    check("late ready valid rose", 32'(bus.data_valid), 32'd1);
    repeat (TIMEOUT - 1) @(posedge clock);
    #1;
    bus.data_ready = 1'b1;
    wait_drain("late ready", 50);
    check("late ready no soft reset", 32'(srst_total - s0), 32'd0);

    // FIFO 0 runs dry mid-payload for 40 cycles.
    @(posedge clock); #1;
    s0 = srst_total;
    h0 = hs_total;
    load_pkt(0, 8'h10, 8'hB1);
    expect_pkt(0, 8'h10, 8'hB1);
    k = 0;
    while (hs_total < h0 + 3 && k < 20) begin @(negedge clock); #1; k++; end
    check("underrun reached payload", 32'(hs_total - h0), 32'd3);
    @(posedge clock); #1;
    force_empty[0] = 1'b1;
    dv_hits = 0;
    repeat (40) begin
      @(negedge clock); #1;
      if (bus.data_valid) dv_hits++;
    end
    check("underrun no valid", 32'(dv_hits), 32'd0);
    check("underrun held", 32'({bus.busy, bus.grant_port}), 32'({1'b1, 2'd0}));
    @(posedge clock); #1;
    force_empty[0] = 1'b0;
    wait_drain("underrun", 50);
    check("underrun no soft reset", 32'(srst_total - s0), 32'd0);

    // Async reset in the middle of a port-1 payload.
    @(posedge clock); #1;
    h0 = hs_total;
    load_pkt(1, 8'h0D, 8'hC1);
    expect_pkt(1, 8'h0D, 8'hC1);
    k = 0;
    while (hs_total < h0 + 2 && k < 20) begin @(negedge clock); #1; k++; end
    check("mid-body busy", 32'({bus.busy, bus.grant_port}), 32'({1'b1, 2'd1}));
    #2;
    resetn = 1'b0;
    #1;
    check("async reset valid", 32'(bus.data_valid), 32'd0);
    check("async reset grant", 32'(bus.grant_port), 32'd3);
    check("async reset read_enb", 32'({bus.read_enb_2, bus.read_enb_1, bus.read_enb_0}), 32'd0);
    check("async reset busy/data", 32'({bus.busy, bus.data_out}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    load_pkt(2, 8'h02, 8'hD2);
    load_pkt(1, 8'h01, 8'hD1);
    load_pkt(0, 8'h00, 8'hD0);
    expect_pkt(0, 8'h00, 8'hD0);
    expect_pkt(1, 8'h01, 8'hD1);
    expect_pkt(2, 8'h02, 8'hD2);
    wait_drain("post reset", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
